// File: rtl/invert_link_rx_pkg.sv
// Shared definitions for the inverter-driven J1 header link receiver:
// state encoding, pin indices and pin polarity.
package invert_link_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DATA_IDX  = 0;
  localparam int SCLK_IDX  = 1;
  localparam int FRAME_IDX = 2;

  // All three J1 pins are driven through inverting buffers.
  localparam logic ACTIVE_LOW = 1'b1;

  function automatic logic to_logical(input logic pin);
    return pin ^ ACTIVE_LOW;
  endfunction

endpackage

// File: rtl/link_sync_edge.sv
// One J1 pin: re-invert, two-flop synchronize, and a third stage for
// rise/fall detection on the synchronized level.
module link_sync_edge
  import invert_link_rx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= to_logical(pin);
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/invert_link_rx.sv
// Receiver for the 3-wire active-low J1 link: synchronizes the pins and
// deframes LSB-first serial data into WIDTH-bit words with a bit-count check.
module invert_link_rx
  import invert_link_rx_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 2)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [2:0]       J1,
  output logic [WIDTH-1:0] O,
  output logic             VALID,
  output logic             ERR,
  output logic             BUSY
);

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_OVR  = CW'(WIDTH + 1);

  logic data_level;
  logic data_rise_unused;
  logic data_fall_unused;
  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall_unused;
  logic frame_level_unused;
  logic frame_start;
  logic frame_end;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shift;

  link_sync_edge u_data (
    .clk   (CLK),
    .reset (RESET),
    .pin   (J1[DATA_IDX]),
    .level (data_level),
    .rise  (data_rise_unused),
    .fall  (data_fall_unused)
  );

  link_sync_edge u_sclk (
    .clk   (CLK),
    .reset (RESET),
    .pin   (J1[SCLK_IDX]),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  link_sync_edge u_frame (
    .clk   (CLK),
    .reset (RESET),
    .pin   (J1[FRAME_IDX]),
    .level (frame_level_unused),
    .rise  (frame_start),
    .fall  (frame_end)
  );

  // Framing FSM; frame_end takes priority over a coincident sclk_rise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      count <= '0;
      shift <= '0;
      O     <= '0;
      VALID <= 1'b0;
      ERR   <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= RECV;
            count <= '0;
            shift <= '0;
            BUSY  <= 1'b1;
          end
        end
        RECV: begin
          if (frame_end) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            if (count == CNT_FULL) begin
              O     <= shift;
              VALID <= 1'b1;
            end else if (count != '0) begin
              ERR <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (count < CNT_FULL) begin
              shift <= {data_level, shift[WIDTH-1:1]};
              count <= count + CW'(1);
            end else begin
              count <= CNT_OVR;
            end
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_invert_link_rx.sv
// Directed, table-driven bench for invert_link_rx (WIDTH=8) with
// hand-written sequences for back-to-back frames and reset mid-frame.
module tb_invert_link_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] j1;
  logic [7:0] o;
  logic       valid;
  logic       err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int   vcnt      = 0;
  int   ecnt      = 0;
  int   both_cnt  = 0;
  int   busy_drop = 0;
  bit   in_frame  = 1'b0;
  logic [7:0] vlog [16];

  invert_link_rx #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RESET (reset),
    .J1    (j1),
    .O     (o),
    .VALID (valid),
    .ERR   (err),
    .BUSY  (busy)
  );

  always #5 clk = ~clk;

  // Pulse and BUSY monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vlog[vcnt % 16] <= o;
      vcnt <= vcnt + 1;
    end
    if (err === 1'b1) ecnt <= ecnt + 1;
    if (valid === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
    if (in_frame && busy !== 1'b1) busy_drop <= busy_drop + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one frame; data bits go out LSB first on SCLK_N falling edges.
  task automatic frame_body(input int nbits, input logic [15:0] data, input bit coincide);
    j1[2] = 1'b0;
    tick(4);
    check("busy_mid", {31'd0, busy}, 32'd1);
    in_frame = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      j1[0] = ~data[i];
      tick(2);
      if (coincide && i == nbits - 1) begin
        in_frame = 1'b0;
        j1[1] = 1'b0;
        j1[2] = 1'b1;
        tick(4);
        j1[1] = 1'b1;
      end else begin
        j1[1] = 1'b0;
        tick(4);
        j1[1] = 1'b1;
        tick(2);
      end
    end
    in_frame = 1'b0;
    j1[2] = 1'b1;
    j1[0] = 1'b1;
  endtask

  typedef struct {
    int         nbits;
    logic [15:0] data;
    bit         coincide;
    int         exp_v;
    int         exp_e;
    logic [7:0] exp_o;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int v0;
    int e0;
    int d0;

    vecs[0] = '{8,  16'h00A5, 1'b0, 1, 0, 8'hA5};
    vecs[1] = '{5,  16'h001F, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{10, 16'h03FF, 1'b0, 0, 1, 8'hA5};
    vecs[3] = '{0,  16'h0000, 1'b0, 0, 0, 8'hA5};
    vecs[4] = '{8,  16'h00FF, 1'b1, 0, 1, 8'hA5};
    vecs[5] = '{8,  16'h0096, 1'b0, 1, 0, 8'h96};

    // Reset with pins toggling, then settle to idle.
    reset = 1'b1;
    j1 = 3'b000;
    tick(1);
    j1 = 3'b101;
    tick(1);
    j1 = 3'b010;
    tick(1);
    j1 = 3'b111;
    tick(2);
    check("rst_o", {24'd0, o}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(6);
    check("rst_no_valid", vcnt, 32'd0);
    check("rst_no_err", ecnt, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      v0 = vcnt;
      e0 = ecnt;
      d0 = busy_drop;
      frame_body(vecs[k].nbits, vecs[k].data, vecs[k].coincide);
      tick(8);
      check($sformatf("vec%0d_valid", k), vcnt - v0, vecs[k].exp_v);
      check($sformatf("vec%0d_err", k), ecnt - e0, vecs[k].exp_e);
      check($sformatf("vec%0d_o", k), {24'd0, o}, {24'd0, vecs[k].exp_o});
      check($sformatf("vec%0d_busy_end", k), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d_busy_drop", k), busy_drop - d0, 32'd0);
    end

    // Back-to-back frames separated by one idle FRAME_N cycle.
    v0 = vcnt;
    e0 = ecnt;
    frame_body(8, 16'h003C, 1'b0);
    tick(1);
    frame_body(8, 16'h00C3, 1'b0);
    tick(8);
    check("b2b_valid", vcnt - v0, 32'd2);
    check("b2b_err", ecnt - e0, 32'd0);
    check("b2b_first", {24'd0, vlog[v0 % 16]}, 32'h3C);
    check("b2b_second", {24'd0, vlog[(v0 + 1) % 16]}, 32'hC3);
    check("b2b_o", {24'd0, o}, 32'hC3);

    // Reset after four bits aborts the frame silently.
    v0 = vcnt;
    e0 = ecnt;
    j1[2] = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      j1[0] = 1'b0;
      tick(2);
      j1[1] = 1'b0;
      tick(4);
      j1[1] = 1'b1;
      tick(2);
    end
    reset = 1'b1;
    j1 = 3'b111;
    tick(2);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_o", {24'd0, o}, 32'd0);
    reset = 1'b0;
    tick(6);
    check("mid_rst_valid", vcnt - v0, 32'd0);
    check("mid_rst_err", ecnt - e0, 32'd0);
    check("mid_rst_busy_after", {31'd0, busy}, 32'd0);

    v0 = vcnt;
    frame_body(8, 16'h005A, 1'b0);
    tick(8);
    check("post_rst_valid", vcnt - v0, 32'd1);
    check("post_rst_o", {24'd0, o}, 32'h5A);
    check("never_both", both_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
